vpe_vadd_arbiter: RTL and testbench
===================================

# vpe_vadd_arbiter

Round-robin arbiter and credit-based scheduler that shares one VPE vector adder (256-bit in, 64-bit out, fixed 2-cycle non-stallable pipeline) between NUM_REQ requesters. It issues one granted 256-bit operand group per cycle with its relu/rf_idx/rf_mux sideband. It tracks the requester ID of every in-flight operation and buffers adder results in a result FIFO. Results are returned tagged with the originating requester ID under a valid/ready handshake.

## Interface
- NUM_REQ, 4: number of requesters; power of two, 2..8.
- ID_W, 2: requester ID width, equal to log2(NUM_REQ).
- ADD_LAT, 2: vector adder latency, from its input-valid to its output-valid.
- FIFO_DEPTH, 8: result FIFO entries; power of two, at least ADD_LAT+1.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req_v  in  NUM_REQ  per-requester operand valid.
- i_req_data  in  NUM_REQ*256  per-requester operand group; slice k is [k*256+255:k*256].
- i_req_en_relu  in  NUM_REQ  per-requester relu enable.
- i_req_rf_idx  in  NUM_REQ*5  per-requester register-file index.
- i_req_rf_mux  in  NUM_REQ*2  per-requester register-file mux select.
- o_req_rdy  out  NUM_REQ  per-requester grant; at most one bit is set.
- o_vadd_data  out  256  operand to the adder; registered.
- o_vadd_data_v  out  1  operand valid to the adder; registered.
- o_vadd_en_relu / o_vadd_rf_idx / o_vadd_rf_mux  out  1/5/2  sideband to the adder; registered.
- i_vadd_data  in  64  adder result.
- i_vadd_data_v  in  1  adder result valid.
- i_vadd_en_relu / i_vadd_rf_idx / i_vadd_rf_mux  in  1/5/2  sideband returned by the adder.
- o_res_data  out  64  result at the FIFO head.
- o_res_v  out  1  result valid.
- o_res_id  out  ID_W  requester ID of the head result.
- o_res_en_relu / o_res_rf_idx / o_res_rf_mux  out  1/5/2  sideband of the head result.
- i_res_rdy  in  1  consumer ready.
- o_busy  out  1  high while any operation is in flight or buffered.
- o_err  out  1  sticky; set on an untracked adder result.

## Operation
- Credit counter cnt (0..FIFO_DEPTH) counts in-flight operations plus FIFO occupancy.
  - cnt increments on issue and decrements on pop (o_res_v & i_res_rdy).
  - When issue and pop happen in the same cycle, cnt is unchanged.
- Issue is allowed only when registered cnt < FIFO_DEPTH. A pop in the same cycle does not create a credit for that cycle.
- Arbitration:
  - Round-robin pointer ptr, reset to 0.
  - The winner is the first k at or after ptr (modulo NUM_REQ) with i_req_v[k]=1.
  - o_req_rdy is combinational: one-hot on the winner when issue is allowed, otherwise all zero.
  - o_req_rdy[k] depends on i_req_v; a requester must not wait for ready before asserting valid.
- Transfer on i_req_v[k] & o_req_rdy[k]. The cycle after a transfer:
  - the o_vadd_* registers hold slice k and o_vadd_data_v=1;
  - ptr = (k+1) mod NUM_REQ.
  - With no transfer, o_vadd_data_v=0, o_vadd_data holds its old value, and ptr holds.
- ID tracking:
  - A valid/ID shift register of ADD_LAT+1 stages is loaded with {1,k} on transfer.
  - Its last stage aligns exactly with i_vadd_data_v.
- On i_vadd_data_v=1, {i_vadd_data, tracked ID, i_vadd sideband} is written to the FIFO.
- If i_vadd_data_v=1 but the last tracking stage is invalid, or the tracking stage is valid but i_vadd_data_v=0:
  - o_err is set;
  - in the first case the entry is dropped, and cnt is unchanged;
  - in the second case cnt is decremented so the lost credit is returned.
- FIFO:
  - First-word fall-through; the o_res_* outputs reflect the head entry.
  - Overflow is impossible by construction.
  - A pop on empty is ignored.
- o_busy = (cnt != 0).

## Timing
- Transfer in cycle t:
  - o_vadd_data_v=1 at t+1;
  - adder result at t+1+ADD_LAT (t+3 by default);
  - written to the FIFO at the end of that cycle;
  - o_res_v=1 at t+4 if the FIFO was empty.
- Sustained throughput is one issue per cycle while cnt < FIFO_DEPTH and i_res_rdy=1.
- With i_res_rdy held at 0, exactly FIFO_DEPTH transfers are accepted, then o_req_rdy is 0 until a pop.
- Reset values:
  - o_req_rdy=0, o_vadd_data_v=0, o_vadd_data=0;
  - o_vadd_en_relu=0, o_vadd_rf_idx=0, o_vadd_rf_mux=0;
  - o_res_v=0, o_res_data=0, o_res_id=0, o_res_* sideband=0;
  - o_busy=0, o_err=0, cnt=0, ptr=0, FIFO empty, tracking pipe invalid.
- Reset asserted mid-operation:
  - all state clears immediately; in-flight and buffered results are discarded;
  - the adder shares this reset, so it emits no stale results afterwards.

## Test plan
- Single requester 2 presents 256'h(all bytes 8'h01) with rf_idx=5, relu=1:
  - o_vadd_data_v=1 one cycle after the handshake;
  - adder returns 64'h0404040404040404;
  - o_res_v=1 with o_res_id=2, o_res_rf_idx=5, o_res_en_relu=1, four cycles after the handshake.
- All 4 requesters hold valid continuously:
  - grants follow 0,1,2,3,0,1,... one per cycle;
  - o_res_id follows the same order, back-to-back.
- i_res_rdy=0 with requesters 0 and 1 always valid:
  - exactly 8 transfers occur, then o_req_rdy=0;
  - one pop at cycle p re-enables exactly one transfer at p+1.
- Simultaneous issue and pop at cnt=7:
  - cnt stays 7 and o_busy stays 1;
  - at cnt=8 a pop with valid requests gives no grant that cycle and one grant the next cycle.
- Inject i_vadd_data_v=1 with nothing in flight:
  - o_err=1 and stays set;
  - no FIFO write; o_res_v stays 0.
- Assert rst with 3 operations in flight and 2 buffered:
  - the next cycle o_res_v=0, o_busy=0, o_err=0;
  - after deassertion the first grant goes to requester 0.

Source files
------------

// File: rtl/vpe_vadd_arbiter.sv
// vpe_vadd_arbiter
// Shares one VPE vector adder (256-bit operand group in, 64-bit result out,
// fixed ADD_LAT-cycle non-stallable pipeline) between NUM_REQ requesters.
// A round-robin arbiter issues at most one operand group per cycle. Issue is
// gated by a credit counter, so every in-flight result is guaranteed a slot
// in the result FIFO. A shift register tags each in-flight operation with its
// requester ID. Results leave through a first-word-fall-through FIFO under a
// valid/ready handshake.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_req_v / o_req_rdy      per-requester valid / grant (o_req_rdy is one-hot)
//   i_req_data               per-requester 256-bit operand group (slice k)
//   i_req_en_relu/rf_idx/rf_mux  per-requester sideband
//   o_vadd_*                 registered operand and sideband to the adder
//   i_vadd_*                 adder result and returned sideband
//   o_res_*                  FIFO head: result, requester ID, sideband, valid
//   i_res_rdy                consumer ready
//   o_busy                   operations in flight or buffered
//   o_err                    sticky: adder result out of step with tracking
module vpe_vadd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int ADD_LAT    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      i_req_v,
  input  logic [NUM_REQ*256-1:0]  i_req_data,
  input  logic [NUM_REQ-1:0]      i_req_en_relu,
  input  logic [NUM_REQ*5-1:0]    i_req_rf_idx,
  input  logic [NUM_REQ*2-1:0]    i_req_rf_mux,
  output logic [NUM_REQ-1:0]      o_req_rdy,
  output logic [255:0]            o_vadd_data,
  output logic                    o_vadd_data_v,
  output logic                    o_vadd_en_relu,
  output logic [4:0]              o_vadd_rf_idx,
  output logic [1:0]              o_vadd_rf_mux,
  input  logic [63:0]             i_vadd_data,
  input  logic                    i_vadd_data_v,
  input  logic                    i_vadd_en_relu,
  input  logic [4:0]              i_vadd_rf_idx,
  input  logic [1:0]              i_vadd_rf_mux,
  output logic [63:0]             o_res_data,
  output logic                    o_res_v,
  output logic [ID_W-1:0]         o_res_id,
  output logic                    o_res_en_relu,
  output logic [4:0]              o_res_rf_idx,
  output logic [1:0]              o_res_rf_mux,
  input  logic                    i_res_rdy,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int FA_W = $clog2(FIFO_DEPTH);
  // FIFO entry layout: {data[63:0], id, relu, rf_idx[4:0], rf_mux[1:0]}
  localparam int E_W = 64 + ID_W + 8;
  localparam logic [FA_W:0] CNT_MAX = (FA_W+1)'(FIFO_DEPTH);

  logic [FA_W:0]                 cnt_r;
  logic [FA_W:0]                 cnt_nx_s;
  logic [ID_W-1:0]               ptr_r;
  logic                          issue_ok_s;
  logic                          win_v_s;
  logic [ID_W-1:0]               win_s;
  logic                          xfer_s;
  logic [ADD_LAT:0]              trk_v_r;
  logic [ADD_LAT:0][ID_W-1:0]    trk_id_r;
  logic [E_W-1:0]                fifo_mem_r [FIFO_DEPTH];
  logic [FA_W-1:0]               wr_ptr_r;
  logic [FA_W-1:0]               rd_ptr_r;
  logic [FA_W:0]                 fill_r;
  logic                          fifo_wr_s;
  logic                          spurious_s;
  logic                          lost_s;
  logic                          pop_s;
  logic [E_W-1:0]                head_s;

  // First requester at or after p with valid set; returns {found, index}.
  // Scanning from the far end lets the nearest candidate overwrite the others.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [ID_W-1:0]    p);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] c;
    res = {(ID_W+1){1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      c = p + ID_W'(i);
      if (v[c]) res = {1'b1, c};
      else      res = res;
    end
    return res;
  endfunction

  // Arbitration, grant and credit bookkeeping
  always_comb begin
    issue_ok_s         = (cnt_r < CNT_MAX);
    {win_v_s, win_s}   = rr_pick(i_req_v, ptr_r);
    xfer_s             = issue_ok_s & win_v_s;
    if (xfer_s) o_req_rdy = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
    else        o_req_rdy = {NUM_REQ{1'b0}};
    fifo_wr_s  = i_vadd_data_v &  trk_v_r[ADD_LAT];
    spurious_s = i_vadd_data_v & ~trk_v_r[ADD_LAT];
    // A tracked op whose result never arrived hands its credit back
    lost_s     = ~i_vadd_data_v & trk_v_r[ADD_LAT];
    o_res_v    = (fill_r != {(FA_W+1){1'b0}});
    pop_s      = o_res_v & i_res_rdy;
    cnt_nx_s   = cnt_r + {{FA_W{1'b0}}, xfer_s} - {{FA_W{1'b0}}, pop_s}
                       - {{FA_W{1'b0}}, lost_s};
    o_busy     = (cnt_r != {(FA_W+1){1'b0}});
  end

  // FIFO head presentation; outputs read zero while the FIFO is empty
  always_comb begin
    head_s = fifo_mem_r[rd_ptr_r];
    if (o_res_v) begin
      o_res_data    = head_s[E_W-1 -: 64];
      o_res_id      = head_s[8 +: ID_W];
      o_res_en_relu = head_s[7];
      o_res_rf_idx  = head_s[6:2];
      o_res_rf_mux  = head_s[1:0];
    end else begin
      o_res_data    = 64'd0;
      o_res_id      = {ID_W{1'b0}};
      o_res_en_relu = 1'b0;
      o_res_rf_idx  = 5'd0;
      o_res_rf_mux  = 2'd0;
    end
  end

  // Issue register: capture the granted slice and advance the round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r          <= {ID_W{1'b0}};
      o_vadd_data_v  <= 1'b0;
      o_vadd_data    <= 256'd0;
      o_vadd_en_relu <= 1'b0;
      o_vadd_rf_idx  <= 5'd0;
      o_vadd_rf_mux  <= 2'd0;
    end else begin
      o_vadd_data_v <= xfer_s;
      if (xfer_s) begin
        o_vadd_data    <= i_req_data[win_s*256 +: 256];
        o_vadd_en_relu <= i_req_en_relu[win_s];
        o_vadd_rf_idx  <= i_req_rf_idx[win_s*5 +: 5];
        o_vadd_rf_mux  <= i_req_rf_mux[win_s*2 +: 2];
        ptr_r          <= win_s + ID_W'(1'b1);
      end
    end
  end

  // ID tracking pipe; stage 0 lines up with o_vadd_data_v, the last stage
  // with the adder's output valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_v_r  <= {(ADD_LAT+1){1'b0}};
      trk_id_r <= {((ADD_LAT+1)*ID_W){1'b0}};
    end else begin
      trk_v_r  <= {trk_v_r[ADD_LAT-1:0], xfer_s};
      trk_id_r <= {trk_id_r[ADD_LAT-1:0], win_s};
    end
  end

  // Credit counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {(FA_W+1){1'b0}};
      o_err <= 1'b0;
    end else begin
      cnt_r <= cnt_nx_s;
      o_err <= o_err | spurious_s | lost_s;
    end
  end

  // Result FIFO pointers and fill level; credits make overflow impossible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {FA_W{1'b0}};
      rd_ptr_r <= {FA_W{1'b0}};
      fill_r   <= {(FA_W+1){1'b0}};
    end else begin
      if (fifo_wr_s) wr_ptr_r <= wr_ptr_r + FA_W'(1'b1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + FA_W'(1'b1);
      fill_r <= fill_r + {{FA_W{1'b0}}, fifo_wr_s} - {{FA_W{1'b0}}, pop_s};
    end
  end

  // Result FIFO storage; contents are masked by the fill level, so no reset
  always_ff @(posedge clk) begin
    if (fifo_wr_s) begin
      fifo_mem_r[wr_ptr_r] <= {i_vadd_data, trk_id_r[ADD_LAT], i_vadd_en_relu,
                               i_vadd_rf_idx, i_vadd_rf_mux};
    end
  end

endmodule

// File: tb/tb_vpe_vadd_arbiter.sv
// Self-checking bench for vpe_vadd_arbiter. Holds a behavioural 2-cycle
// adder (sum of the four 64-bit lanes) and a queue-based reference model:
// every issued op is queued with the cycle its result becomes visible;
// credits are simply the queue length.
module tb_vpe_vadd_arbiter;
  localparam int NUM_REQ = 4, ID_W = 2, ADD_LAT = 2, FIFO_DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]     i_req_v = '0;
  logic [NUM_REQ*256-1:0] i_req_data = '0;
  logic [NUM_REQ-1:0]     i_req_en_relu = '0;
  logic [NUM_REQ*5-1:0]   i_req_rf_idx = '0;
  logic [NUM_REQ*2-1:0]   i_req_rf_mux = '0;
  logic [NUM_REQ-1:0]     o_req_rdy;
  logic [255:0] o_vadd_data;
  logic o_vadd_data_v, o_vadd_en_relu;
  logic [4:0] o_vadd_rf_idx;
  logic [1:0] o_vadd_rf_mux;
  logic [63:0] i_vadd_data;
  logic i_vadd_data_v, i_vadd_en_relu;
  logic [4:0] i_vadd_rf_idx;
  logic [1:0] i_vadd_rf_mux;
  logic [63:0] o_res_data;
  logic o_res_v, o_res_en_relu;
  logic [ID_W-1:0] o_res_id;
  logic [4:0] o_res_rf_idx;
  logic [1:0] o_res_rf_mux;
  logic i_res_rdy = 1'b1;
  logic o_busy, o_err;
  logic [1:0] inj = 2'd0;  // 0 normal, 1 force adder valid, 2 suppress it

  vpe_vadd_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADD_LAT(ADD_LAT),
                     .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .i_req_v(i_req_v), .i_req_data(i_req_data),
    .i_req_en_relu(i_req_en_relu), .i_req_rf_idx(i_req_rf_idx),
    .i_req_rf_mux(i_req_rf_mux), .o_req_rdy(o_req_rdy),
    .o_vadd_data(o_vadd_data), .o_vadd_data_v(o_vadd_data_v),
    .o_vadd_en_relu(o_vadd_en_relu), .o_vadd_rf_idx(o_vadd_rf_idx),
    .o_vadd_rf_mux(o_vadd_rf_mux), .i_vadd_data(i_vadd_data),
    .i_vadd_data_v(i_vadd_data_v), .i_vadd_en_relu(i_vadd_en_relu),
    .i_vadd_rf_idx(i_vadd_rf_idx), .i_vadd_rf_mux(i_vadd_rf_mux),
    .o_res_data(o_res_data), .o_res_v(o_res_v), .o_res_id(o_res_id),
    .o_res_en_relu(o_res_en_relu), .o_res_rf_idx(o_res_rf_idx),
    .o_res_rf_mux(o_res_rf_mux), .i_res_rdy(i_res_rdy), .o_busy(o_busy),
    .o_err(o_err));

  function automatic logic [63:0] lane_sum(input logic [255:0] d);
    return d[63:0] + d[127:64] + d[191:128] + d[255:192];
  endfunction

  // Behavioural adder: fixed two-stage pipe sharing the reset
  logic a1_v, a2_v;
  logic [63:0] a1_d, a2_d;
  logic [7:0] a1_sb, a2_sb;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_v <= 1'b0; a2_v <= 1'b0; a1_d <= '0; a2_d <= '0; a1_sb <= '0; a2_sb <= '0;
    end else begin
      a1_v <= o_vadd_data_v; a1_d <= lane_sum(o_vadd_data);
      a1_sb <= {o_vadd_en_relu, o_vadd_rf_idx, o_vadd_rf_mux};
      a2_v <= a1_v; a2_d <= a1_d; a2_sb <= a1_sb;
    end
  end
  assign i_vadd_data_v  = (inj == 2'd1) ? 1'b1 : (inj == 2'd2) ? 1'b0 : a2_v;
  assign i_vadd_data    = a2_d;
  assign i_vadd_en_relu = a2_sb[7];
  assign i_vadd_rf_idx  = a2_sb[6:2];
  assign i_vadd_rf_mux  = a2_sb[1:0];

  typedef struct {
    int id; logic [63:0] d; logic [7:0] sb; int rc;
  } ent_t;
  ent_t q[$];
  int m_ptr = 0;
  int cyc = 0;
  logic m_vv = 1'b0;
  logic [255:0] m_vdata = '0;
  logic [7:0] m_vsb = '0;
  logic m_err = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check outputs against the model, advance the model, move to next negedge
  task automatic tick();
    logic [NUM_REQ-1:0] exp_rdy;
    int k;
    bit exp_v;
    ent_t e;
    #1;
    exp_rdy = '0;
    k = -1;
    if (q.size() < FIFO_DEPTH) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int c;
        c = (m_ptr + i) % NUM_REQ;
        if (k < 0 && i_req_v[c]) k = c;
      end
    end
    if (k >= 0) exp_rdy[k] = 1'b1;
    chk("req_rdy", o_req_rdy, exp_rdy);
    chk("vadd_v", o_vadd_data_v, m_vv);
    chk("vadd_data", o_vadd_data, m_vdata);
    chk("vadd_sb", {o_vadd_en_relu, o_vadd_rf_idx, o_vadd_rf_mux}, m_vsb);
    exp_v = (q.size() > 0) && (q[0].rc <= cyc);
    chk("res_v", o_res_v, exp_v);
    if (exp_v) begin
      chk("res_data", o_res_data, q[0].d);
      chk("res_id", o_res_id, q[0].id);
      chk("res_sb", {o_res_en_relu, o_res_rf_idx, o_res_rf_mux}, q[0].sb);
    end
    chk("busy", o_busy, q.size() != 0);
    chk("err", o_err, m_err);
    if (exp_v && i_res_rdy) void'(q.pop_front());
    m_vv = (k >= 0);
    if (k >= 0) begin
      m_vdata = i_req_data[k*256 +: 256];
      m_vsb   = {i_req_en_relu[k], i_req_rf_idx[k*5 +: 5], i_req_rf_mux[k*2 +: 2]};
      e.id = k; e.d = lane_sum(m_vdata); e.sb = m_vsb; e.rc = cyc + 1 + ADD_LAT + 1;
      q.push_back(e);
      m_ptr = (k + 1) % NUM_REQ;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req_v = '0; i_res_rdy = 1'b1; inj = 2'd0;
    repeat (2) @(negedge clk);
    q.delete(); m_ptr = 0; m_vv = 1'b0; m_vdata = '0; m_vsb = '0; m_err = 1'b0; cyc = 0;
    rst = 1'b0;
  endtask

  task automatic rand_inputs(input int rdy_pct);
    i_req_v = NUM_REQ'($urandom);
    for (int j = 0; j < NUM_REQ*8; j++) i_req_data[j*32 +: 32] = $urandom;
    i_req_en_relu = NUM_REQ'($urandom);
    i_req_rf_idx  = (NUM_REQ*5)'($urandom);
    i_req_rf_mux  = (NUM_REQ*2)'($urandom);
    i_res_rdy     = ($urandom_range(0, 99) < rdy_pct);
  endtask

  initial begin
    int n;
    @(negedge clk);
    do_reset();
    // Reset state
    chk("rst_req_rdy", o_req_rdy, 4'b0000);
    chk("rst_vadd_v", o_vadd_data_v, 1'b0);
    chk("rst_vadd_data", o_vadd_data, 256'd0);
    chk("rst_vadd_sb", {o_vadd_en_relu, o_vadd_rf_idx, o_vadd_rf_mux}, 8'd0);
    chk("rst_res", {o_res_v, o_res_data, o_res_id}, '0);
    chk("rst_res_sb", {o_res_en_relu, o_res_rf_idx, o_res_rf_mux}, 8'd0);
    chk("rst_busy_err", {o_busy, o_err}, 2'b00);

    // Single requester 2, all-0x01 operand, rf_idx 5, relu 1
    i_req_v = 4'b0100;
    i_req_data[2*256 +: 256] = {32{8'h01}};
    i_req_rf_idx = '0; i_req_rf_idx[10 +: 5] = 5'd5;
    i_req_en_relu = 4'b0100; i_req_rf_mux = '0;
    tick();
    i_req_v = '0;
    chk("single_vadd_v", o_vadd_data_v, 1'b1);
    repeat (3) tick();
    chk("single_res_v", o_res_v, 1'b1);
    chk("single_res_id", o_res_id, 2'd2);
    chk("single_res_idx", o_res_rf_idx, 5'd5);
    chk("single_res_relu", o_res_en_relu, 1'b1);
    chk("single_res_data", o_res_data, 64'h0404040404040404);
    repeat (2) tick();

    // All four requesters valid: strict rotation 0,1,2,3,...
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rand_inputs(100);
      i_req_v = 4'hF; i_res_rdy = 1'b1;
      #1;
      chk("rr_order", o_req_rdy, 4'b0001 << (i % 4));
      tick();
    end
    i_req_v = '0;
    repeat (6) tick();

    // Backpressure: exactly FIFO_DEPTH transfers, then single regrant per pop
    do_reset();
    i_res_rdy = 1'b0; i_req_v = 4'b0011;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if ((o_req_rdy & i_req_v) != '0) n++;
      tick();
    end
    chk("bp_xfer_count", n, FIFO_DEPTH);
    i_res_rdy = 1'b1;
    #1 chk("bp_no_grant_on_pop", o_req_rdy, 4'b0000);
    tick();
    i_res_rdy = 1'b0;
    #1 chk("bp_regrant", $countones(o_req_rdy), 1);
    tick();
    #1 chk("bp_full_again", o_req_rdy, 4'b0000);
    tick();
    // Drop to 7 credits, then issue and pop together
    i_req_v = '0; i_res_rdy = 1'b1;
    tick();
    i_req_v = 4'b0011;
    #1 chk("cnt7_grant", $countones(o_req_rdy), 1);
    tick();
    chk("cnt7_busy", o_busy, 1'b1);
    i_res_rdy = 1'b0;
    #1 chk("cnt7_one_more", $countones(o_req_rdy), 1);
    tick();
    #1 chk("cnt8_blocked", o_req_rdy, 4'b0000);
    tick();
    i_req_v = '0; i_res_rdy = 1'b1;
    repeat (12) tick();

    // Spurious adder result with nothing in flight
    do_reset();
    inj = 2'd1;
    tick();
    inj = 2'd0; m_err = 1'b1;
    chk("spur_err", o_err, 1'b1);
    repeat (3) tick();
    chk("spur_err_sticky", o_err, 1'b1);
    chk("spur_no_res", o_res_v, 1'b0);

    // Tracked op whose result is suppressed: credit returned, error set
    do_reset();
    i_req_v = 4'b0010;
    tick();
    i_req_v = '0;
    repeat (2) tick();
    inj = 2'd2;
    tick();
    inj = 2'd0; m_err = 1'b1;
    void'(q.pop_front());
    chk("lost_err", o_err, 1'b1);
    chk("lost_busy", o_busy, 1'b0);
    repeat (2) tick();

    // Reset with 3 in flight and 2 buffered
    do_reset();
    i_res_rdy = 1'b0; i_req_v = 4'hF;
    repeat (5) tick();
    i_req_v = '0;
    chk("pre_rst_busy", {o_busy, o_res_v}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_res_v", o_res_v, 1'b0);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_err", o_err, 1'b0);
    do_reset();
    i_req_v = 4'hF;
    #1 chk("post_rst_grant", o_req_rdy, 4'b0001);
    i_req_v = '0;
    repeat (6) tick();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rand_inputs((i < 200) ? 90 : (i < 400) ? 25 : (i < 500) ? 0 : 60);
      tick();
    end
    i_req_v = '0; i_res_rdy = 1'b1;
    repeat (16) tick();
    chk("drain_busy", o_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
